// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: merges fetch and load/store requests onto one memory bus,
// one transaction in flight, with response-ID matching and a response timeout.
module mem_port_arbiter #(
   parameter int unsigned ID_W    = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            reset,

   input  logic            f_req_valid,
   input  logic [63:0]     f_req_addr,
   input  logic [ID_W-1:0] f_req_id,
   output logic            f_req_ready,
   output logic            f_resp_valid,
   output logic [63:0]     f_resp_data,

   input  logic            ls_req_valid,
   input  logic            ls_req_write,
   input  logic [63:0]     ls_req_addr,
   input  logic [63:0]     ls_req_wdata,
   input  logic [ID_W-1:0] ls_req_id,
   output logic            ls_req_ready,
   output logic            ls_resp_valid,
   output logic [63:0]     ls_resp_data,

   output logic            mem_req_valid,
   output logic            mem_req_write,
   output logic [63:0]     mem_req_addr,
   output logic [63:0]     mem_req_wdata,
   output logic [ID_W-1:0] mem_req_id,
   input  logic            mem_req_busy,
   input  logic            mem_resp_valid,
   input  logic [ID_W-1:0] mem_resp_id,
   input  logic [63:0]     mem_resp_data,

   output logic            err_timeout,
   output logic [31:0]     fetch_wait_cnt
);

   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t            state;
   logic              last_ls;   // last acceptance went to load/store
   logic              owner_ls;  // current transaction belongs to load/store
   logic [ID_W-1:0]   cap_id;    // ID kept for response matching after issue
   logic [CNT_W-1:0]  wait_cnt;
   logic              grant_f;
   logic              grant_ls;

   // Alternating priority: on a tie the port not granted last time wins.
   always_comb begin
      grant_f  = f_req_valid  && (!ls_req_valid || last_ls);
      grant_ls = ls_req_valid && (!f_req_valid  || !last_ls);
   end

   // Acceptance is only possible in IDLE and never while reset is held.
   assign f_req_ready  = !reset && (state == ST_IDLE) && grant_f;
   assign ls_req_ready = !reset && (state == ST_IDLE) && grant_ls;

   // Transaction FSM, registered outputs and stall counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         last_ls        <= 1'b1;
         owner_ls       <= 1'b0;
         cap_id         <= '0;
         wait_cnt       <= '0;
         mem_req_valid  <= 1'b0;
         mem_req_write  <= 1'b0;
         mem_req_addr   <= '0;
         mem_req_wdata  <= '0;
         mem_req_id     <= '0;
         f_resp_valid   <= 1'b0;
         f_resp_data    <= '0;
         ls_resp_valid  <= 1'b0;
         ls_resp_data   <= '0;
         err_timeout    <= 1'b0;
         fetch_wait_cnt <= '0;
      end else begin
         if (f_req_valid && !f_req_ready && (fetch_wait_cnt != {CNT_W{1'b1}}))
            fetch_wait_cnt <= fetch_wait_cnt + CNT_W'(1);

         case (state)
            ST_IDLE: begin
               if (f_req_ready) begin
                  owner_ls      <= 1'b0;
                  last_ls       <= 1'b0;
                  cap_id        <= f_req_id;
                  mem_req_valid <= 1'b1;
                  mem_req_write <= 1'b0;
                  mem_req_addr  <= f_req_addr;
                  mem_req_wdata <= '0;
                  mem_req_id    <= f_req_id;
                  state         <= ST_ISSUE;
               end else if (ls_req_ready) begin
                  owner_ls      <= 1'b1;
                  last_ls       <= 1'b1;
                  cap_id        <= ls_req_id;
                  mem_req_valid <= 1'b1;
                  mem_req_write <= ls_req_write;
                  mem_req_addr  <= ls_req_addr;
                  mem_req_wdata <= ls_req_wdata;
                  mem_req_id    <= ls_req_id;
                  state         <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               if (!mem_req_busy) begin
                  mem_req_valid <= 1'b0;
                  mem_req_write <= 1'b0;
                  mem_req_addr  <= '0;
                  mem_req_wdata <= '0;
                  mem_req_id    <= '0;
                  wait_cnt      <= '0;
                  state         <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (mem_resp_valid && (mem_resp_id == cap_id)) begin
                  if (owner_ls) begin
                     ls_resp_valid <= 1'b1;
                     ls_resp_data  <= mem_resp_data;
                  end else begin
                     f_resp_valid  <= 1'b1;
                     f_resp_data   <= mem_resp_data;
                  end
                  state <= ST_RESP;
               end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            ST_RESP: begin
               f_resp_valid  <= 1'b0;
               f_resp_data   <= '0;
               ls_resp_valid <= 1'b0;
               ls_resp_data  <= '0;
               state         <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model, per-cycle compare, directed scenarios.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int unsigned ID_W = 8;
   localparam int unsigned TMO  = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic            f_req_valid, f_req_ready, f_resp_valid;
   logic [63:0]     f_req_addr, f_resp_data;
   logic [ID_W-1:0] f_req_id;
   logic            ls_req_valid, ls_req_write, ls_req_ready, ls_resp_valid;
   logic [63:0]     ls_req_addr, ls_req_wdata, ls_resp_data;
   logic [ID_W-1:0] ls_req_id;
   logic            mem_req_valid, mem_req_write, mem_req_busy, mem_resp_valid;
   logic [63:0]     mem_req_addr, mem_req_wdata, mem_resp_data;
   logic [ID_W-1:0] mem_req_id, mem_resp_id;
   logic            err_timeout;
   logic [31:0]     fetch_wait_cnt;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ID_W(ID_W), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_id(f_req_id),
      .f_req_ready(f_req_ready), .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
      .ls_req_valid(ls_req_valid), .ls_req_write(ls_req_write), .ls_req_addr(ls_req_addr),
      .ls_req_wdata(ls_req_wdata), .ls_req_id(ls_req_id), .ls_req_ready(ls_req_ready),
      .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_id(mem_req_id), .mem_req_busy(mem_req_busy),
      .mem_resp_valid(mem_resp_valid), .mem_resp_id(mem_resp_id), .mem_resp_data(mem_resp_data),
      .err_timeout(err_timeout), .fetch_wait_cnt(fetch_wait_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired, got no event want event", name);
   endtask

   // ---------------- transaction-level model ----------------
   logic            m_txn, m_sent, m_strobe, m_owner_ls, m_last_ls, m_err;
   logic            m_write;
   logic [63:0]     m_addr, m_wdata, m_data;
   logic [ID_W-1:0] m_id;
   int              m_wait;
   logic [31:0]     m_fwait;

   function automatic logic m_idle();
      return !m_txn && !m_strobe;
   endfunction
   function automatic logic exp_f_ready();
      return !reset && m_idle() && f_req_valid && (!ls_req_valid || m_last_ls);
   endfunction
   function automatic logic exp_ls_ready();
      return !reset && m_idle() && ls_req_valid && (!f_req_valid || !m_last_ls);
   endfunction

   // Model advance: one step per clock, dropped entirely on reset.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_txn <= 1'b0; m_sent <= 1'b0; m_strobe <= 1'b0; m_owner_ls <= 1'b0;
         m_last_ls <= 1'b1; m_err <= 1'b0; m_write <= 1'b0; m_addr <= '0;
         m_wdata <= '0; m_data <= '0; m_id <= '0; m_wait <= 0; m_fwait <= '0;
      end else begin
         if (f_req_valid && !exp_f_ready() && (m_fwait != 32'hFFFF_FFFF))
            m_fwait <= m_fwait + 32'd1;
         if (m_strobe) begin
            m_strobe <= 1'b0;
         end else if (!m_txn) begin
            if (exp_f_ready()) begin
               m_txn <= 1'b1; m_sent <= 1'b0; m_owner_ls <= 1'b0; m_last_ls <= 1'b0;
               m_write <= 1'b0; m_addr <= f_req_addr; m_wdata <= '0; m_id <= f_req_id;
            end else if (exp_ls_ready()) begin
               m_txn <= 1'b1; m_sent <= 1'b0; m_owner_ls <= 1'b1; m_last_ls <= 1'b1;
               m_write <= ls_req_write; m_addr <= ls_req_addr; m_wdata <= ls_req_wdata;
               m_id <= ls_req_id;
            end
         end else if (!m_sent) begin
            if (!mem_req_busy) begin
               m_sent <= 1'b1;
               m_wait <= 0;
            end
         end else if (mem_resp_valid && (mem_resp_id == m_id)) begin
            m_txn <= 1'b0; m_strobe <= 1'b1; m_data <= mem_resp_data;
         end else if (m_wait + 1 == int'(TMO)) begin
            m_txn <= 1'b0; m_err <= 1'b1;
         end else begin
            m_wait <= m_wait + 1;
         end
      end
   end

   // Per-cycle compare of every DUT output against the model.
   initial begin
      forever begin
         logic mv, fv, lv;
         @(negedge clk);
         mv = m_txn && !m_sent;
         fv = m_strobe && !m_owner_ls;
         lv = m_strobe && m_owner_ls;
         check("f_req_ready",    64'(f_req_ready),    64'(exp_f_ready()));
         check("ls_req_ready",   64'(ls_req_ready),   64'(exp_ls_ready()));
         check("mem_req_valid",  64'(mem_req_valid),  64'(mv));
         check("mem_req_write",  64'(mem_req_write),  mv ? 64'(m_write) : 64'd0);
         check("mem_req_addr",   mem_req_addr,        mv ? m_addr : 64'd0);
         check("mem_req_wdata",  mem_req_wdata,       mv ? m_wdata : 64'd0);
         check("mem_req_id",     64'(mem_req_id),     mv ? 64'(m_id) : 64'd0);
         check("f_resp_valid",   64'(f_resp_valid),   64'(fv));
         check("f_resp_data",    f_resp_data,         fv ? m_data : 64'd0);
         check("ls_resp_valid",  64'(ls_resp_valid),  64'(lv));
         check("ls_resp_data",   ls_resp_data,        lv ? m_data : 64'd0);
         check("err_timeout",    64'(err_timeout),    64'(m_err));
         check("fetch_wait_cnt", 64'(fetch_wait_cnt), 64'(m_fwait));
      end
   end

   // ---------------- event monitor for literal checks ----------------
   int          cyc = 0;
   int          f_pulses = 0, ls_pulses = 0, memv_cycles = 0;
   int          f_acc_cyc = 0, f_resp_cyc = 0, err_cyc = 0;
   logic        err_seen = 1'b0;
   logic [63:0] f_last = '0;
   logic        grant_log[$];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (f_resp_valid) begin
         f_pulses   <= f_pulses + 1;
         f_last     <= f_resp_data;
         f_resp_cyc <= cyc;
      end
      if (ls_resp_valid) ls_pulses <= ls_pulses + 1;
      if (mem_req_valid) memv_cycles <= memv_cycles + 1;
      if (f_req_ready) begin
         f_acc_cyc <= cyc;
         grant_log.push_back(1'b0);
      end
      if (ls_req_ready) grant_log.push_back(1'b1);
      if (err_timeout && !err_seen) begin
         err_seen <= 1'b1;
         err_cyc  <= cyc;
      end
   end

   // ---------------- memory responder ----------------
   int          cfg_busy = 0, cfg_delay = 0;
   logic        cfg_wrong = 1'b0, cfg_noresp = 1'b0;
   logic [63:0] cfg_data = '0;
   logic [ID_W-1:0] resp_id;
   int          late_req = 0, late_done = 0;

   initial begin
      mem_req_busy = 1'b0; mem_resp_valid = 1'b0; mem_resp_id = '0; mem_resp_data = '0;
      forever begin
         @(posedge clk); #1;
         if (late_req != late_done) begin
            mem_resp_valid = 1'b1; mem_resp_id = 8'h01; mem_resp_data = 64'hFEED;
            @(posedge clk); #1;
            mem_resp_valid = 1'b0; mem_resp_id = '0; mem_resp_data = '0;
            late_done = late_req;
         end else if (mem_req_valid && !reset) begin
            resp_id = mem_req_id;
            if (cfg_busy > 0) begin
               mem_req_busy = 1'b1;
               repeat (cfg_busy) begin @(posedge clk); #1; end
               mem_req_busy = 1'b0;
            end
            @(posedge clk); #1;
            if (!cfg_noresp) begin
               repeat (cfg_delay) begin @(posedge clk); #1; end
               if (cfg_wrong) begin
                  mem_resp_valid = 1'b1; mem_resp_id = 8'h22; mem_resp_data = 64'hBAD0_BAD0;
                  @(posedge clk); #1;
               end
               mem_resp_valid = 1'b1; mem_resp_id = resp_id; mem_resp_data = cfg_data;
               @(posedge clk); #1;
               mem_resp_valid = 1'b0; mem_resp_id = '0; mem_resp_data = '0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_fetch(input logic [63:0] a, input logic [ID_W-1:0] id);
      f_req_valid = 1'b1; f_req_addr = a; f_req_id = id;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (f_req_ready) begin
            @(posedge clk); #1;
            f_req_valid = 1'b0; f_req_addr = '0; f_req_id = '0;
            return;
         end
      end
      timeout_fail("fetch_accept");
      f_req_valid = 1'b0;
   endtask

   task automatic send_ls(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [ID_W-1:0] id);
      ls_req_valid = 1'b1; ls_req_write = w; ls_req_addr = a; ls_req_wdata = d; ls_req_id = id;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ls_req_ready) begin
            @(posedge clk); #1;
            ls_req_valid = 1'b0; ls_req_write = 1'b0; ls_req_addr = '0;
            ls_req_wdata = '0; ls_req_id = '0;
            return;
         end
      end
      timeout_fail("ls_accept");
      ls_req_valid = 1'b0;
   endtask

   task automatic wait_pulses(input int fexp, input int lexp, input string name);
      for (int i = 0; i < 100; i++) begin
         if (f_pulses >= fexp && ls_pulses >= lexp) begin
            cycles(2);
            return;
         end
         cycles(1);
      end
      timeout_fail(name);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(1);
   endtask

   initial begin
      int fp, lp, mv0, g0;
      logic [31:0] fw0;
      reset = 1'b1;
      f_req_valid = 1'b1; f_req_addr = 64'h40; f_req_id = 8'h01;
      ls_req_valid = 1'b0; ls_req_write = 1'b0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_id = '0;
      cycles(3);
      f_req_valid = 1'b0; f_req_addr = '0; f_req_id = '0;
      cycles(1);
      reset = 1'b0;
      cycles(2);
      check("rst_mem_req_valid",  64'(mem_req_valid),  64'd0);
      check("rst_f_resp_valid",   64'(f_resp_valid),   64'd0);
      check("rst_ls_resp_valid",  64'(ls_resp_valid),  64'd0);
      check("rst_err_timeout",    64'(err_timeout),    64'd0);
      check("rst_fetch_wait_cnt", 64'(fetch_wait_cnt), 64'd0);

      // Basic fetch read with a response two cycles after issue.
      cfg_busy = 0; cfg_delay = 1; cfg_wrong = 1'b0; cfg_noresp = 1'b0;
      cfg_data = 64'hDEADBEEF_00000013;
      fp = f_pulses; lp = ls_pulses; mv0 = memv_cycles;
      send_fetch(64'h100, 8'h01);
      wait_pulses(fp + 1, lp, "fetch_resp_wait");
      check("fetch_pulses",  64'(f_pulses - fp),        64'd1);
      check("fetch_ls_none", 64'(ls_pulses - lp),       64'd0);
      check("fetch_data",    f_last,                    64'hDEADBEEF_00000013);
      check("fetch_latency", 64'(f_resp_cyc - f_acc_cyc), 64'd4);
      check("fetch_memv",    64'(memv_cycles - mv0),    64'd1);
      check("fetch_nostall", 64'(fetch_wait_cnt),       64'd0);

      // Tie arbitration from reset: F, LS, then F, LS again.
      do_reset();
      cfg_delay = 0; cfg_data = 64'h1111_2222_3333_4444;
      fp = f_pulses; lp = ls_pulses; g0 = grant_log.size();
      fork
         send_fetch(64'h300, 8'h03);
         send_ls(1'b0, 64'h308, 64'h0, 8'h04);
      join
      fork
         send_fetch(64'h310, 8'h03);
         send_ls(1'b0, 64'h318, 64'h0, 8'h04);
      join
      wait_pulses(fp + 2, lp + 2, "tie_resp_wait");
      check("tie_grants", 64'(grant_log.size() - g0), 64'd4);
      if (grant_log.size() >= g0 + 4) begin
         check("tie_g0", 64'(grant_log[g0]),     64'd0);
         check("tie_g1", 64'(grant_log[g0 + 1]), 64'd1);
         check("tie_g2", 64'(grant_log[g0 + 2]), 64'd0);
         check("tie_g3", 64'(grant_log[g0 + 3]), 64'd1);
      end

      // Load/store write held through three busy cycles.
      cfg_busy = 3; cfg_delay = 0; cfg_data = 64'h0;
      fp = f_pulses; lp = ls_pulses; mv0 = memv_cycles;
      send_ls(1'b1, 64'h200, 64'h55, 8'h07);
      wait_pulses(fp, lp + 1, "busy_resp_wait");
      check("busy_memv",  64'(memv_cycles - mv0), 64'd4);
      check("busy_ls",    64'(ls_pulses - lp),    64'd1);
      check("busy_f",     64'(f_pulses - fp),     64'd0);

      // Mismatched response IDs ignored; fetch stalls behind an ls transaction.
      cfg_busy = 0; cfg_delay = 0; cfg_wrong = 1'b1; cfg_data = 64'h0123_4567_89AB_CDEF;
      fp = f_pulses; lp = ls_pulses; fw0 = fetch_wait_cnt;
      send_ls(1'b0, 64'h400, 64'h0, 8'h05);
      send_fetch(64'h408, 8'h01);
      wait_pulses(fp + 1, lp + 1, "id_resp_wait");
      check("id_stall",  64'(fetch_wait_cnt - fw0), 64'd4);
      check("id_fdata",  f_last,                    64'h0123_4567_89AB_CDEF);
      check("id_ls",     64'(ls_pulses - lp),       64'd1);

      // No response: abort after TIMEOUT wait cycles, then keep serving.
      cfg_wrong = 1'b0; cfg_noresp = 1'b1;
      fp = f_pulses; lp = ls_pulses;
      check("pre_to_err", 64'(err_timeout), 64'd0);
      send_fetch(64'h500, 8'h09);
      for (int i = 0; i < 40 && !err_timeout; i++) cycles(1);
      if (!err_timeout) timeout_fail("timeout_wait");
      cycles(2);
      check("to_err",     64'(err_timeout),        64'd1);
      check("to_timing",  64'(err_cyc - f_acc_cyc), 64'd10);
      check("to_nopulse", 64'(f_pulses - fp),      64'd0);
      cfg_noresp = 1'b0; cfg_data = 64'hAAAA;
      send_ls(1'b0, 64'h600, 64'h0, 8'h0A);
      wait_pulses(fp, lp + 1, "after_to_wait");
      check("after_to_ls",  64'(ls_pulses - lp), 64'd1);
      check("after_to_err", 64'(err_timeout),    64'd1);

      // Reset during WAIT, then a late response that must be ignored.
      cfg_noresp = 1'b1;
      fp = f_pulses; lp = ls_pulses;
      send_fetch(64'h700, 8'h01);
      cycles(3);
      #2 reset = 1'b1;
      #1;
      check("arst_mem_req_valid", 64'(mem_req_valid),  64'd0);
      check("arst_f_resp_valid",  64'(f_resp_valid),   64'd0);
      check("arst_err",           64'(err_timeout),    64'd0);
      check("arst_fwait",         64'(fetch_wait_cnt), 64'd0);
      cycles(2);
      reset = 1'b0;
      late_req = late_req + 1;
      cycles(5);
      check("late_f",  64'(f_pulses - fp),  64'd0);
      check("late_ls", 64'(ls_pulses - lp), 64'd0);
      cfg_noresp = 1'b0; cfg_data = 64'h5A5A;
      send_fetch(64'h800, 8'h0B);
      wait_pulses(fp + 1, lp, "post_rst_wait");
      check("post_rst_f",    64'(f_pulses - fp), 64'd1);
      check("post_rst_data", f_last,             64'h5A5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang want finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ID_W, default 8, bus-ID width (core id + component type).
REQ-002 SHALL have parameter TIMEOUT, default 1024, max response-wait cycles before abort.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
clk  in  1  clock
reset  in  1  async active-high reset
f_req_valid  in  1  fetch read request
f_req_addr  in  64  fetch address (8-byte aligned)
f_req_id  in  ID_W  fetch bus ID
f_req_ready  out  1  fetch request accepted this cycle
f_resp_valid  out  1  fetch response strobe
f_resp_data  out  64  fetch response payload
ls_req_valid  in  1  load/store request
ls_req_write  in  1  1=write, 0=read
ls_req_addr  in  64  load/store address
ls_req_wdata  in  64  write data
ls_req_id  in  ID_W  load/store bus ID
ls_req_ready  out  1  load/store request accepted this cycle
ls_resp_valid  out  1  load/store response strobe
ls_resp_data  out  64  read data (don't-care for writes)
mem_req_valid  out  1  request to memory bus
mem_req_write  out  1  request type
mem_req_addr  out  64  request address
mem_req_wdata  out  64  write data
mem_req_id  out  ID_W  request bus ID
mem_req_busy  in  1  memory bus cannot accept
mem_resp_valid  in  1  memory response strobe
mem_resp_id  in  ID_W  response bus ID
mem_resp_data  in  64  response payload
err_timeout  out  1  sticky: response timeout occurred
fetch_wait_cnt  out  32  cycles fetch was stalled

Function
REQ-005 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; at most one transaction outstanding.
REQ-006 IDLE: f_req_ready = f_req_valid and grant_f; ls_req_ready = ls_req_valid and grant_ls (combinational); on the accepting edge capture owner, write, addr, wdata, id; go ISSUE.
REQ-007 Grant: single requester wins; both valid -> the one NOT recorded in last_grant; last_grant updates on each acceptance.
REQ-008 Fetch requests SHALL be issued as reads (mem_req_write=0).
REQ-009 ISSUE: mem_req_valid=1 with captured fields held stable; edge with mem_req_busy=0 -> WAIT; busy=1 -> stay.
REQ-010 WAIT: mem_resp_valid with mem_resp_id == captured id -> register mem_resp_data, go RESP; mismatched id ignored, stay.
REQ-011 WAIT: 32-bit wait counter cleared on ISSUE->WAIT, increments per WAIT cycle; reaching TIMEOUT -> set err_timeout, go IDLE, no response to owner.
REQ-012 RESP: owner's resp_valid=1 for exactly one cycle with registered data; other resp_valid=0; go IDLE.
REQ-013 Requests outside IDLE SHALL see ready=0; requesters hold valid and fields until ready.
REQ-014 Minimum latency: accept edge N, mem_req_valid in cycle N+1, response strobe one cycle after matching mem_resp_valid.
REQ-015 fetch_wait_cnt increments each cycle f_req_valid=1 and f_req_ready=0; saturates at 0xFFFFFFFF.
REQ-016 mem_resp_valid outside WAIT SHALL be ignored.
REQ-017 Outputs outside their active state SHALL be 0 (mem_req_*, *_resp_valid, *_resp_data).

Reset
REQ-018 Reset asserted: state=IDLE, last_grant=LS (fetch wins first tie), all outputs 0, err_timeout=0, fetch_wait_cnt=0, counters 0; immediate, any state, in-flight transaction dropped.
REQ-019 err_timeout SHALL clear only on reset.

Verification
REQ-020 Fetch read 0x100 id 0x01, busy=0, resp id 0x01 data 0xDEADBEEF_00000013 two cycles after issue -> f_resp_valid one cycle with that data; ls outputs 0.
REQ-021 Both valid same cycle after reset -> fetch granted first, ls granted next IDLE; a further tie grants fetch again.
REQ-022 ls write 0x200 data 0x55, mem_req_busy=1 for 3 cycles -> mem_req_valid held 4 cycles with stable fields; ack -> ls_resp_valid one pulse.
REQ-023 WAIT with resp id 0x22 then 0x01 (captured 0x01) -> first ignored, second delivered; fetch_wait_cnt counts pending fetch cycles.
REQ-024 TIMEOUT=8, no response -> after 8 WAIT cycles err_timeout=1, state IDLE, no resp_valid, next request served.
REQ-025 Reset asserted in WAIT -> all outputs 0 asynchronously; late mem_resp_valid after release ignored.
